// File: rtl/mem_responder.sv
// Memory-side target of a four-phase req/ack handshake.
// Byte-addressed big-endian storage with a fixed number of wait states,
// word/half/byte accesses and an alignment-error flag.
//
// state | meaning
// IDLE  | waiting for req; a request is accepted on the first edge it is seen
// WAIT  | counting down wait states; the access happens when cnt reaches 0
// RESP  | ack held high until the initiator drops req
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state;
  state_t                 nextState;
  logic [3:0]             cnt;
  logic                   latWe;
  logic [1:0]             latSize;
  logic [ADDR_BITS-1:0]   latAddr;
  logic [31:0]            latWdata;
  logic [7:0]             mem [DEPTH];

  logic                   accept;
  logic                   doAccess;
  logic                   aligned;
  logic [ADDR_BITS-1:0]   a1;
  logic [ADDR_BITS-1:0]   a2;
  logic [ADDR_BITS-1:0]   a3;
  logic [31:0]            readWord;

  // Upper address bits are deliberately dropped so accesses wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[31:ADDR_BITS];

  assign accept   = (state == IDLE) && req;
  assign doAccess = (state == WAIT) && (cnt == 4'd0);
  assign ack      = (state == RESP);
  assign busy     = (state != IDLE);

  assign a1 = latAddr + ADDR_BITS'(1);
  assign a2 = latAddr + ADDR_BITS'(2);
  assign a3 = latAddr + ADDR_BITS'(3);

  // Alignment check on the latched request; the reserved size is always illegal.
  always_comb begin
    aligned = 1'b0;
    case (latSize)
      2'b00:   aligned = (latAddr[1:0] == 2'b00);
      2'b01:   aligned = (latAddr[0] == 1'b0);
      2'b10:   aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  // Big-endian read assembly, zero-extended for half/byte.
  always_comb begin
    readWord = 32'h0;
    case (latSize)
      2'b00:   readWord = {mem[latAddr], mem[a1], mem[a2], mem[a3]};
      2'b01:   readWord = {16'h0, mem[latAddr], mem[a1]};
      default: readWord = {24'h0, mem[latAddr]};
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; RESP is held while req stays high so a request is never taken twice.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req) nextState = WAIT;
      WAIT:    if (cnt == 4'd0) nextState = RESP;
      RESP:    if (!req) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture and wait-state down-counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= 4'd0;
      latWe    <= 1'b0;
      latSize  <= 2'b00;
      latAddr  <= '0;
      latWdata <= 32'h0;
    end else if (accept) begin
      cnt      <= CNT_INIT;
      latWe    <= we;
      latSize  <= size;
      latAddr  <= addr[ADDR_BITS-1:0];
      latWdata <= wdata;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data and error flag; rdata only moves on a successful read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= 32'h0;
      err   <= 1'b0;
    end else if (doAccess) begin
      err <= !aligned;
      if (aligned && !latWe) rdata <= readWord;
    end else if ((state == RESP) && !req) begin
      err <= 1'b0;
    end
  end

  // Storage writes; contents survive reset, and an aborted request never reaches doAccess.
  always_ff @(posedge clock) begin
    if (doAccess && aligned && latWe) begin
      case (latSize)
        2'b00: begin
          mem[latAddr] <= latWdata[31:24];
          mem[a1]      <= latWdata[23:16];
          mem[a2]      <= latWdata[15:8];
          mem[a3]      <= latWdata[7:0];
        end
        2'b01: begin
          mem[latAddr] <= latWdata[15:8];
          mem[a1]      <= latWdata[7:0];
        end
        default: mem[latAddr] <= latWdata[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 2, 1, 5) driven
// from a table of transactions, plus hand-written reset-abort sequence.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  ack;
  logic [2:0]  busy;
  logic [2:0]  err;
  logic [1:0]  size  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u0 (
    .clock(clock), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]),
    .busy(busy[0]), .err(err[0]));

  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]),
    .busy(busy[1]), .err(err[1]));

  mem_responder #(.ADDR_BITS(8), .LATENCY(5)) u2 (
    .clock(clock), .reset(reset), .req(req[2]), .we(we[2]), .size(size[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]),
    .busy(busy[2]), .err(err[2]));

  localparam logic [1:0] WORD = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] BYTE = 2'b10;
  localparam logic [1:0] RSV  = 2'b11;

  typedef struct {
    int          d;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
    int          lat;
    logic        e;
    logic [31:0] rd;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input int d, input logic w, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, input int hold,
                              input int lat, input logic e, input logic [31:0] rd,
                              input string nm);
    vec_t v;
    v.d = d; v.w = w; v.sz = sz; v.a = a; v.wd = wd; v.hold = hold;
    v.lat = lat; v.e = e; v.rd = rd; v.nm = nm;
    vecs.push_back(v);
  endfunction

  // One full four-phase transaction; returns the measured latency and response.
  task automatic txn(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input string nm,
                     output int lat, output logic e, output logic [31:0] rd);
    @(negedge clock);
    req[d] = 1'b1; we[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    @(posedge clock); #1;
    check({nm, " busy after accept"}, 32'(busy[d]), 32'd1);
    check({nm, " ack low after accept"}, 32'(ack[d]), 32'd0);
    // Scramble the request fields while the responder is waiting; they must be ignored.
    @(negedge clock);
    we[d] = ~w; size[d] = ~sz; addr[d] = ~a; wdata[d] = ~wd;
    lat = 0;
    while (!ack[d] && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!ack[d]) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no ack after %0d edges", nm, lat);
    end
    e  = err[d];
    rd = rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({nm, " ack held"}, 32'(ack[d]), 32'd1);
    end
    @(negedge clock);
    req[d] = 1'b0;
    @(posedge clock); #1;
    check({nm, " ack drop"}, 32'(ack[d]), 32'd0);
    check({nm, " busy drop"}, 32'(busy[d]), 32'd0);
    check({nm, " err drop"}, 32'(err[d]), 32'd0);
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rd;

    req = '0;
    we  = '0;
    for (int i = 0; i < 3; i++) begin
      size[i] = WORD; addr[i] = 32'h0; wdata[i] = 32'h0;
    end

    // dut, we, size, addr, wdata, hold, latency, err, rdata, name
    add(0, 1, WORD, 32'h10, 32'hDEADBEEF, 0, 2, 0, 32'h00000000, "w word 10");
    add(0, 0, WORD, 32'h10, 32'h0,        0, 2, 0, 32'hDEADBEEF, "r word 10");
    add(0, 0, BYTE, 32'h11, 32'h0,        0, 2, 0, 32'h000000AD, "r byte 11");
    add(0, 1, WORD, 32'h20, 32'h11223344, 0, 2, 0, 32'h000000AD, "w word 20");
    add(0, 1, HALF, 32'h22, 32'hAAAA5555, 0, 2, 0, 32'h000000AD, "w half 22");
    add(0, 0, WORD, 32'h20, 32'h0,        0, 2, 0, 32'h11225555, "r word 20");
    add(0, 1, BYTE, 32'h20, 32'h00000077, 0, 2, 0, 32'h11225555, "w byte 20");
    add(0, 0, WORD, 32'h20, 32'h0,        0, 2, 0, 32'h77225555, "r word 20 b");
    add(0, 1, WORD, 32'h30, 32'hCAFEF00D, 0, 2, 0, 32'h77225555, "w word 30");
    add(0, 1, WORD, 32'h31, 32'h12345678, 0, 2, 1, 32'h77225555, "w word 31 misal");
    add(0, 0, WORD, 32'h30, 32'h0,        0, 2, 0, 32'hCAFEF00D, "r word 30");
    add(0, 0, HALF, 32'h33, 32'h0,        0, 2, 1, 32'hCAFEF00D, "r half 33 misal");
    add(0, 0, RSV,  32'h30, 32'h0,        5, 2, 1, 32'hCAFEF00D, "r rsv hold5");
    add(0, 1, BYTE, 32'hFFFFFF04, 32'h5A, 0, 2, 0, 32'hCAFEF00D, "w byte wrap");
    add(0, 0, BYTE, 32'h04, 32'h0,        0, 2, 0, 32'h0000005A, "r byte 04");
    add(0, 0, HALF, 32'h12, 32'h0,        0, 2, 0, 32'h0000BEEF, "r half 12");
    add(0, 1, WORD, 32'h40, 32'h0BADF00D, 0, 2, 0, 32'h0000BEEF, "w word 40");
    add(1, 1, WORD, 32'h08, 32'h01020304, 0, 1, 0, 32'h00000000, "lat1 w word 08");
    add(1, 0, HALF, 32'h0A, 32'h0,        0, 1, 0, 32'h00000304, "lat1 r half 0a");
    add(1, 0, BYTE, 32'hABCDEF0B, 32'h0,  0, 1, 0, 32'h00000004, "lat1 r byte wrap");
    add(2, 1, BYTE, 32'h09, 32'h00000099, 0, 5, 0, 32'h00000000, "lat5 w byte 09");
    add(2, 0, BYTE, 32'h09, 32'h0,        0, 5, 0, 32'h00000099, "lat5 r byte 09");

    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ack %0d", i),   32'(ack[i]),  32'd0);
      check($sformatf("reset busy %0d", i),  32'(busy[i]), 32'd0);
      check($sformatf("reset err %0d", i),   32'(err[i]),  32'd0);
      check($sformatf("reset rdata %0d", i), rdata[i],     32'h0);
    end
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[k]) begin
      txn(vecs[k].d, vecs[k].w, vecs[k].sz, vecs[k].a, vecs[k].wd, vecs[k].hold,
          vecs[k].nm, lat, e, rd);
      check({vecs[k].nm, " latency"}, 32'(lat), 32'(vecs[k].lat));
      check({vecs[k].nm, " err"},     32'(e),   32'(vecs[k].e));
      check({vecs[k].nm, " rdata"},   rd,       vecs[k].rd);
    end

    // Reset while a word write to 0x40 is still waiting: nothing may be written.
    @(negedge clock);
    req[0] = 1'b1; we[0] = 1'b1; size[0] = WORD; addr[0] = 32'h40; wdata[0] = 32'hFFFFFFFF;
    @(posedge clock); #1;
    check("abort busy before reset", 32'(busy[0]), 32'd1);
    @(negedge clock);
    reset  = 1'b0;
    req[0] = 1'b0;
    #1;
    check("abort ack",   32'(ack[0]),  32'd0);
    check("abort busy",  32'(busy[0]), 32'd0);
    check("abort err",   32'(err[0]),  32'd0);
    check("abort rdata", rdata[0],     32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    txn(0, 1'b0, WORD, 32'h40, 32'h0, 0, "r word 40 after abort", lat, e, rd);
    check("r word 40 after abort latency", 32'(lat), 32'd2);
    check("r word 40 after abort err",     32'(e),   32'd0);
    check("r word 40 after abort rdata",   rd,       32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side target for the CPU's memory port: it is the responding end of a four-phase req/ack handshake.
- Provides byte-addressed, big-endian storage with a configurable number of wait states.
- Supports word, halfword and byte accesses, and flags misaligned accesses.
- Lets the multicycle control FSM be exercised against a memory that does not answer in a fixed single cycle.

Parameters:
ADDR_BITS, 8, byte-address width of the storage (2^ADDR_BITS bytes); addr[31:ADDR_BITS] is ignored, so accesses wrap.
LATENCY, 2, clock edges from request acceptance to ack assertion; legal range 1..15.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  1  request from the initiator; four-phase.
we  input  1  1 = write, 0 = read; sampled at acceptance.
size  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as a misaligned access).
addr  input  32  byte address; sampled at acceptance.
wdata  input  32  write data, right-aligned for half/byte; sampled at acceptance.
rdata  output  32  read data, zero-extended for half/byte.
ack  output  1  response valid / transaction complete.
busy  output  1  high from acceptance until return to IDLE.
err  output  1  alignment error for the current response; valid while ack = 1.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; ack, busy, err = 0; rdata = 0; wait counter = 0.
  - Storage contents are not cleared.
  - A transaction in flight is aborted; if the access has not yet been performed, no bytes are written.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with req = 1: latch we, size, addr[ADDR_BITS-1:0] and wdata; set cnt = LATENCY-1; set busy = 1; go to WAIT.
  - req = 0: stay in IDLE.
- WAIT:
  - cnt != 0: decrement cnt.
  - cnt == 0: perform the access, then go to RESP with ack = 1.
  - ack therefore rises exactly LATENCY edges after the accepting edge.
  - req and the other inputs are ignored in WAIT; changes to them have no effect.
- Alignment:
  - word requires addr[1:0] = 00; half requires addr[0] = 0; size = 11 is always an error.
  - On error: no write and no rdata update; err = 1 in RESP.
- Big-endian byte lanes (a = latched address):
  - Word read: rdata = {m[a], m[a+1], m[a+2], m[a+3]}.
  - Half read: rdata = {16'h0, m[a], m[a+1]}.
  - Byte read: rdata = {24'h0, m[a]}.
  - Word write: m[a] = wdata[31:24], m[a+1] = wdata[23:16], m[a+2] = wdata[15:8], m[a+3] = wdata[7:0].
  - Half write: m[a] = wdata[15:8], m[a+1] = wdata[7:0].
  - Byte write: m[a] = wdata[7:0].
  - Only the addressed bytes change.
- Writes: rdata holds its previous value.
- rdata persistence: it updates only on a successful read and is held until the next successful read.
- RESP:
  - ack = 1 while req = 1.
  - On the edge where req = 0: ack = 0, err = 0, busy = 0; go to IDLE.
  - A new request is accepted from IDLE on the next edge at the earliest, i.e. a minimum gap of one idle cycle.
- req held high across ack falling: impossible by protocol. The FSM stays in RESP until req drops, so a request is never double-accepted.
- Reading a never-written location after power-up returns X. Benches must write before reading.

Test Plan:
- Word write/read, LATENCY = 2:
  - Write 0xDEADBEEF to addr 0x10; ack rises 2 edges after acceptance, err = 0.
  - Read addr 0x10 -> rdata = 0xDEADBEEF.
  - Byte read of addr 0x11 -> 0x000000AD.
- Half/byte lane writes:
  - Word-write 0x11223344 to addr 0x20.
  - Half-write 0xAAAA5555 to addr 0x22.
  - Word read of addr 0x20 -> 0x11225555.
  - Byte-write 0x77 to addr 0x20, then word read -> 0x77225555.
- Misalignment:
  - Word write to addr 0x31 -> ack with err = 1; addr 0x30..0x33 unchanged; rdata unchanged.
  - Half read of addr 0x33 -> err = 1.
- Handshake:
  - Hold req high for 5 cycles after ack -> ack stays 1, exactly one access occurs.
  - Drop req -> ack and busy fall on the next edge; a new req one cycle later is accepted.
- Wrap and latency:
  - Write with addr = 0xFFFFFF04, ADDR_BITS = 8 -> byte 0x04 updated.
  - Repeat with LATENCY = 1 and LATENCY = 5 -> ack at 1 and 5 edges after acceptance respectively.
- Reset mid-operation:
  - Assert reset during WAIT of a word write to 0x40 -> ack, busy, err immediately 0; after release, a read of 0x40 returns the prior contents.
